// File: rtl/riscv_imm_pkg.sv
// Immediate format codes, field positions and packing helper shared
// by the immediate sign-extender and the immediate packer.
package riscv_imm_pkg;

    typedef enum logic [1:0] {
        IMM_I    = 2'b00,
        IMM_S    = 2'b01,
        IMM_B    = 2'b10,
        IMM_RSVD = 2'b11
    } imm_src_e;

    localparam int I_IMM_HI  = 31;
    localparam int I_IMM_LO  = 20;
    localparam int S_HI_HI   = 31;
    localparam int S_HI_LO   = 25;
    localparam int S_LO_HI   = 11;
    localparam int S_LO_LO   = 7;
    localparam int B_SIGN    = 31;
    localparam int B_B11     = 7;
    localparam int B_MID_HI  = 30;
    localparam int B_MID_LO  = 25;
    localparam int B_LOW_HI  = 11;
    localparam int B_LOW_LO  = 8;

    typedef struct packed {
        imm_src_e    src;
        logic [31:0] imm;
        logic [31:0] base;
        logic        range_err;
        logic        align_err;
        logic        fmt_err;
    } s1_t;

    // Scatter imm into base; bits outside the format's fields pass through.
    function automatic logic [31:0] pack_imm(
        imm_src_e    src,
        logic [31:0] imm,
        logic [31:0] base
    );
        logic [31:0] w;
        w = base;
        unique case (src)
            IMM_I: w[I_IMM_HI:I_IMM_LO] = imm[11:0];
            IMM_S: begin
                w[S_HI_HI:S_HI_LO] = imm[11:5];
                w[S_LO_HI:S_LO_LO] = imm[4:0];
            end
            IMM_B: begin
                w[B_SIGN]            = imm[12];
                w[B_B11]             = imm[11];
                w[B_MID_HI:B_MID_LO] = imm[10:5];
                w[B_LOW_HI:B_LOW_LO] = imm[4:1];
            end
            default: w = base;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Decides whether an immediate is representable in the requested
// format and flags misaligned branch offsets and reserved formats.
module imm_range_check
    import riscv_imm_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [31:0] imm_value,
    output logic        range_err,
    output logic        align_err,
    output logic        fmt_err
);

    logic fits_12;
    logic fits_13;
    logic unused_bits;

    assign fits_12 = (&imm_value[31:11]) | ~(|imm_value[31:11]);
    assign fits_13 = (&imm_value[31:12]) | ~(|imm_value[31:12]);
    assign unused_bits = ^imm_value[10:1];

    always_comb begin
        range_err = 1'b0;
        align_err = 1'b0;
        fmt_err   = 1'b0;
        unique case (imm_src_e'(imm_src))
            IMM_I: range_err = ~fits_12;
            IMM_S: range_err = ~fits_12;
            IMM_B: begin
                range_err = ~fits_13;
                align_err = imm_value[0];
            end
            default: fmt_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_packer.sv
// Two-stage valid/ready immediate packer: check, then scatter into
// instruction fields; counts delivered words that carry any error.
module imm_packer
    import riscv_imm_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           imm_src,
    input  logic [31:0]          imm_value,
    input  logic [31:0]          base_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 range_err,
    output logic                 align_err,
    output logic                 fmt_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic s1_valid;
    s1_t  s1_q;
    logic adv1;
    logic adv2;
    logic chk_range;
    logic chk_align;
    logic chk_fmt;
    logic out_hs;
    logic out_any_err;

    imm_range_check u_check (
        .imm_src   (imm_src),
        .imm_value (imm_value),
        .range_err (chk_range),
        .align_err (chk_align),
        .fmt_err   (chk_fmt)
    );

    assign adv2        = ~out_valid | out_ready;
    assign adv1        = ~s1_valid | adv2;
    assign in_ready    = adv1;
    assign out_hs      = out_valid & out_ready;
    assign out_any_err = range_err | align_err | fmt_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q.src       <= imm_src_e'(imm_src);
                s1_q.imm       <= imm_value;
                s1_q.base      <= base_instr;
                s1_q.range_err <= chk_range;
                s1_q.align_err <= chk_align;
                s1_q.fmt_err   <= chk_fmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= '0;
            range_err <= 1'b0;
            align_err <= 1'b0;
            fmt_err   <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                instr     <= pack_imm(s1_q.src, s1_q.imm, s1_q.base);
                range_err <= s1_q.range_err;
                align_err <= s1_q.align_err;
                fmt_err   <= s1_q.fmt_err;
            end
        end
    end

    // Clear wins over a simultaneous erroring handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (out_hs && out_any_err && !(&err_count)) begin
            err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
